// File: rtl/score_keeper.sv
// score_keeper: counts shots and hits per game, holds each result on display, gates shooting, tracks high score.
// Ports: clk, reset (sync, active-high), ena (global enable), start_new_game (level),
//        result_valid/hit (shot result in), shoot_enable/in_play/hit_flash/game_over (status out),
//        score/shots_left/high_score (4-bit counters out).
// Optional feature: define SCORE_STREAK_BONUS_EN to award 2 points for hits on a streak of 3 or more.
module score_keeper #(
    parameter int SHOTS_PER_GAME = 8,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       start_new_game,
    input  logic       result_valid,
    input  logic       hit,
    output logic       shoot_enable,
    output logic       in_play,
    output logic       hit_flash,
    output logic       game_over,
    output logic [3:0] score,
    output logic [3:0] shots_left,
    output logic [3:0] high_score
);
    typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;
    localparam logic [3:0] SHOTS     = 4'(SHOTS_PER_GAME);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
    state_t     r_state, w_state_nxt;
    logic       r_rv_d, r_hit_flash;
    logic [3:0] r_score, r_shots_left, r_high_score;
    logic [7:0] r_hold_cnt;
    logic       w_event, w_shot, w_hold_done;
    logic [1:0] w_inc;
    logic [4:0] w_sum;
`ifdef SCORE_STREAK_BONUS_EN
    logic [3:0] r_streak, w_streak_inc;
    assign w_streak_inc = (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
    assign w_inc        = (w_streak_inc >= 4'd3) ? 2'd2 : 2'd1;
`else
    assign w_inc = 2'd1;
`endif
    // Rising edge of result_valid, so a held level scores only once.
    assign w_event     = result_valid & ~r_rv_d;
    assign w_shot      = (r_state == PLAY) && w_event;
    assign w_hold_done = (r_state == HOLD) && (r_hold_cnt == 8'd0);
    assign w_sum       = {1'b0, r_score} + {3'b0, w_inc};
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else if (ena)
            r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt  = start_new_game ? PLAY :
                       w_shot         ? HOLD :
                       w_hold_done    ? ((r_shots_left == 4'd0) ? OVER : PLAY) :
                       r_state;
        shoot_enable = (r_state == PLAY);
        in_play      = (r_state == PLAY) || (r_state == HOLD);
        game_over    = (r_state == OVER);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rv_d       <= 1'b0;
            r_hit_flash  <= 1'b0;
            r_score      <= 4'd0;
            r_shots_left <= 4'd0;
            r_high_score <= 4'd0;
            r_hold_cnt   <= 8'd0;
`ifdef SCORE_STREAK_BONUS_EN
            r_streak     <= 4'd0;
`endif
        end else if (ena) begin
            r_rv_d <= result_valid;
            if (start_new_game) begin
                r_score      <= 4'd0;
                r_shots_left <= SHOTS;
                r_hit_flash  <= 1'b0;
`ifdef SCORE_STREAK_BONUS_EN
                r_streak     <= 4'd0;
`endif
            end else if (w_shot) begin
                r_shots_left <= r_shots_left - 4'd1;
                r_hit_flash  <= hit;
                r_hold_cnt   <= HOLD_INIT;
                if (hit)
                    r_score <= w_sum[4] ? 4'hF : w_sum[3:0];
`ifdef SCORE_STREAK_BONUS_EN
                r_streak <= hit ? w_streak_inc : 4'd0;
`endif
            end else if (r_state == HOLD) begin
                if (r_hold_cnt != 8'd0)
                    r_hold_cnt <= r_hold_cnt - 8'd1;
                else begin
                    r_hit_flash <= 1'b0;
                    // Leaving HOLD with no shots left is the HOLD->OVER transition.
                    if (r_shots_left == 4'd0 && r_score > r_high_score)
                        r_high_score <= r_score;
                end
            end
        end
    end
    assign hit_flash  = r_hit_flash;
    assign score      = r_score;
    assign shots_left = r_shots_left;
    assign high_score = r_high_score;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus checked against a cycle-count based game model.
module tb_score_keeper;
    localparam int S = 8;
    localparam int H = 16;
`ifdef SCORE_STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0, ena = 1'b0, start_new_game = 1'b0, result_valid = 1'b0, hit = 1'b0;
    logic shoot_enable, in_play, hit_flash, game_over;
    logic [3:0] score, shots_left, high_score;
    int n_cmp = 0, n_bad = 0;
    int m_mode = 0, m_score = 0, m_shots = 0, m_streak = 0, m_high = 0, m_flash = 0, m_prev_rv = 0;
    longint m_ticks = 0, m_release = 0;
    always #5 clk = ~clk;
    score_keeper #(.SHOTS_PER_GAME(S), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .ena(ena), .start_new_game(start_new_game),
        .result_valid(result_valid), .hit(hit), .shoot_enable(shoot_enable),
        .in_play(in_play), .hit_flash(hit_flash), .game_over(game_over),
        .score(score), .shots_left(shots_left), .high_score(high_score)
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    // Game model in terms of modes (0 idle, 1 play, 2 hold, 3 over) and an enabled-cycle clock:
    // a shot at enabled tick T releases the hold at tick T+H.
    task automatic model();
        int ev;
        if (reset) begin
            m_mode = 0; m_score = 0; m_shots = 0; m_streak = 0; m_high = 0; m_flash = 0; m_prev_rv = 0;
        end else if (ena) begin
            m_ticks++;
            ev = (result_valid && !m_prev_rv) ? 1 : 0;
            m_prev_rv = result_valid ? 1 : 0;
            if (start_new_game) begin
                m_mode = 1; m_score = 0; m_shots = S; m_streak = 0; m_flash = 0;
            end else if (m_mode == 1 && ev == 1) begin
                m_shots--;
                m_flash = hit ? 1 : 0;
                if (hit) begin
                    m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
                    m_score += (BONUS && m_streak >= 3) ? 2 : 1;
                    if (m_score > 15) m_score = 15;
                end else
                    m_streak = 0;
                m_mode = 2;
                m_release = m_ticks + H;
            end else if (m_mode == 2 && m_ticks == m_release) begin
                m_flash = 0;
                if (m_shots == 0) begin
                    m_mode = 3;
                    if (m_score > m_high) m_high = m_score;
                end else
                    m_mode = 1;
            end
        end
    endtask
    task automatic compare();
        chk("shoot_enable", 8'(shoot_enable), 8'(m_mode == 1));
        chk("in_play", 8'(in_play), 8'(m_mode == 1 || m_mode == 2));
        chk("game_over", 8'(game_over), 8'(m_mode == 3));
        chk("hit_flash", 8'(hit_flash), 8'(m_flash));
        chk("score", 8'(score), 8'(m_score));
        chk("shots_left", 8'(shots_left), 8'(m_shots));
        chk("high_score", 8'(high_score), 8'(m_high));
    endtask
    task automatic step(input logic rs, input logic en, input logic st, input logic rv, input logic h);
        reset = rs; ena = en; start_new_game = st; result_valid = rv; hit = h;
        @(posedge clk);
        model();
        #1;
        compare();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic shot(input logic h, input int gap);
        step(1'b0, 1'b1, 1'b0, 1'b1, h);
        idle(gap);
    endtask
    initial begin
        int zeros;
        logic rv;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_flags", {4'd0, shoot_enable, in_play, hit_flash, game_over}, 8'd0);
        chk("rst_counts", {score, shots_left}, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("start_shots", 8'(shots_left), 8'd8);
        chk("start_shoot", 8'(shoot_enable), 8'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("hit_score", 8'(score), 8'd1);
        chk("hit_shots", 8'(shots_left), 8'd7);
        chk("hit_flash1", 8'(hit_flash), 8'd1);
        zeros = shoot_enable ? 0 : 1;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (!shoot_enable) zeros++;
        end
        chk("hold_len", 8'(zeros), 8'd16);
        chk("hold_end_flash", 8'(hit_flash), 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("level_once", 8'(shots_left), 8'd7);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        chk("hold_ignore", 8'(shots_left), 8'd6);
        idle(20);
        shot(1'b1, 3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) shot(i inside {0, 2, 3, 5}, 18);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(15);
        chk("over_early", 8'(game_over), 8'd0);
        idle(1);
        chk("over_on_time", 8'(game_over), 8'd1);
        chk("over_score", 8'(score), 8'd5);
        chk("over_high", 8'(high_score), 8'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) shot(i < 2, 18);
        chk("high_kept", 8'(high_score), 8'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) shot(1'b1, 18);
        chk("all_hits", 8'(score), BONUS ? 8'd14 : 8'd8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        shot(1'b1, 18);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("collide_shots", 8'(shots_left), 8'd8);
        chk("collide_score", 8'(score), 8'd0);
        idle(1);
        shot(1'b1, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_hold", {shoot_enable, in_play, hit_flash, game_over, score}, 8'd0);
        chk("rst_mid_hold_cnt", {shots_left, high_score}, 8'd0);
        rv = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0) rv = ~rv;
            step($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 299) == 0, rv, 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
